instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Streaming RV32I instruction encoder; the inverse of the core's instruction decoder.
//  Accepts decoded fields (class, funct3, alt bit, rd/rs1/rs2, 32-bit imm) over valid/ready.
//  Emits packed 32-bit instruction words through a 2-stage pipeline with backpressure.
//  Used by the program loader/self-test path to write instruction memory, and as decoder round-trip checker.
// PARAMETERS
//  CNT_W   16   width of the encoded-word and error counters (saturating)
// PORTS
//  clk         in   1    clock; all state updates on rising edge
//  reset       in   1    synchronous, active-high reset
//  in_valid    in   1    input field bundle valid
//  in_ready    out  1    encoder accepts bundle this cycle
//  in_class    in   4    instruction class (enc_class.vh: OP,OP_IMM,LOAD,STORE,BRANCH,JAL,JALR,LUI,AUIPC)
//  in_funct3   in   3    funct3 field
//  in_alt      in   1    SUB/SRA/SRAI select -> instr[30]
//  in_rd       in   5    destination register
//  in_rs1      in   5    source register 1
//  in_rs2      in   5    source register 2
//  in_imm      in   32   immediate as full value; the U-type value is pre-shifted, e.g. 0x12345000
//  out_valid   out  1    out_instr valid
//  out_ready   in   1    downstream accepts word
//  out_instr   out  32   encoded instruction
//  out_err     out  1    word failed a legality/range check; qualified by out_valid
//  enc_count   out  CNT_W  words handed off (out_valid&&out_ready); saturates at all-ones
//  err_count   out  CNT_W  handed-off words with out_err=1; saturates
// BEHAVIOUR
//  - Reset: s1/s2 valid cleared (in-flight words dropped), out_valid=0, out_instr=0, out_err=0, counters=0.
//  - Stage 1 registers class/fields plus the range-check result. Stage 2 registers the packed word (out_*).
//  - s2 advance = !s2_valid || out_ready; s1 advance = !s1_valid || s2 advance.
//  - in_ready = s1 advance (combinational from out_ready). Fully pipelined: 1 word/cycle while out_ready=1.
//  - Latency: accept at edge N -> out_valid at edge N+2 when unstalled.
//  - Stalled outputs hold out_instr/out_err stable until handshake.
//  - Packing: R {alt?0x20:0,rs2,rs1,f3,rd,op}; I/JALR/LOAD imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7];
//    B {imm12,imm10:5,rs2,rs1,f3,imm4:1,imm11}; J {imm20,imm10:1,imm11,imm19:12,rd}; U imm[31:12]->[31:12].
//  - OP_IMM shifts (f3 001/101): [31:25]={0,alt,00000}, [24:20]=imm[4:0]. Fields not used by the class are packed as 0.
//  - Unknown in_class: out_instr=0x00000013 (NOP), out_err=1 regardless of macro.
//  - Counters increment only on the output handshake, never on reset cycles.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined: out_err=1 if the imm does not fit the field. Words are still emitted, truncated.
//   - Signed I/S: -2048..2047. B: -4096..4094. J: -2^20..2^20-2.
//   - Unsigned, matching the core decoder's zero-extension: SLTIU, LBU/LHU: 0..4095; BLTU/BGEU: 0..8190.
//   - B/J: imm[0]=1 is an error. Shifts: imm>31 is an error. U: imm[11:0]!=0 is an error.
//  Not defined: no range logic; out_err only flags unknown class; silent truncation.
// STRUCTURE
//  - Class codes in shared include enc_class.vh; major opcodes reused from op_code.vh.
//  - One sub-module imm_range_check (combinational, class+f3+imm -> err), instantiated only under ENC_RANGE_CHECK_EN.
// TESTING
//  1 ADDI x1,x0,5 (OP_IMM,f3=0,rd=1,imm=5), out_ready=1 -> 0x00500093, err=0, two cycles after accept.
//  2 SUB x3,x1,x2 (OP,alt=1) -> 0x402081B3. BEQ x1,x2,+8 -> 0x00208463. JAL x1,+2048 -> 0x001000EF.
//    LUI x5,0x12345000 -> 0x123452B7. All words feed the core decoder; decoded fields must match the stimulus.
//  3 ADDI imm=2048 -> err=1 with ENC_RANGE_CHECK_EN, err=0 without. BEQ imm=3 -> err=1 with the macro.
//    in_class=4'hF -> 0x00000013, err=1 in both builds.
//  4 Stream 8 words back-to-back, hold out_ready=0 for 3 cycles mid-stream.
//    Required: in_ready drops once both stages are full, no loss or duplication, order kept, enc_count=8.
//  5 reset asserted with 2 words in flight -> next cycle out_valid=0, counters=0; the next accepted word emerges clean.
//  6 Force enc_count to all-ones (CNT_W=4 build, 17 words) -> enc_count stays 15.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: class codes, major opcodes, helpers.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_OP     = 4'd0,
    CLS_OP_IMM = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } enc_class_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_known_class(input logic [3:0] cls);
    return cls <= 4'(CLS_AUIPC);
  endfunction

  // SLLI/SRLI/SRAI use a 5-bit shamt instead of a 12-bit immediate
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_range_check.sv
// Combinational immediate legality check (class + funct3 + imm -> err).
// Only instantiated when ENC_RANGE_CHECK_EN is defined.
module imm_range_check
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic        err
);

  // True when v is a sign-extended n-bit two's complement value
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] hi;
    hi = 32'hFFFF_FFFF << (n - 1);
    return ((v & hi) == 32'd0) || ((v & hi) == hi);
  endfunction

  always_comb begin
    err = 1'b0;
    case (cls)
      CLS_OP_IMM: begin
        if (is_shift(funct3))
          err = (imm[31:5] != '0);
        else if (funct3 == 3'b011)
          err = (imm[31:12] != '0);
        else
          err = !fits_signed(imm, 12);
      end
      CLS_LOAD: begin
        if ((funct3 == 3'b100) || (funct3 == 3'b101))
          err = (imm[31:12] != '0);
        else
          err = !fits_signed(imm, 12);
      end
      CLS_JALR, CLS_STORE: err = !fits_signed(imm, 12);
      CLS_BRANCH: begin
        if ((funct3 == 3'b110) || (funct3 == 3'b111))
          err = (imm[31:13] != '0) || imm[0];
        else
          err = !fits_signed(imm, 13) || imm[0];
      end
      CLS_JAL:             err = !fits_signed(imm, 21) || imm[0];
      CLS_LUI, CLS_AUIPC:  err = (imm[11:0] != '0);
      default:             err = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: decoded fields in, packed instruction words out, 2-stage pipeline.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_alt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic        s1_valid_reg, s2_valid_reg;
  logic [3:0]  s1_class_reg;
  logic [2:0]  s1_funct3_reg;
  logic        s1_alt_reg, s1_err_reg;
  logic [4:0]  s1_rd_reg, s1_rs1_reg, s1_rs2_reg;
  logic [31:0] s1_imm_reg;
  logic [31:0] out_instr_reg;
  logic        out_err_reg;
  logic [31:0] pack_word;
  logic        range_err;
  logic        s1_adv, s2_adv, handshake;

  assign s2_adv    = !s2_valid_reg || out_ready;
  assign s1_adv    = !s1_valid_reg || s2_adv;
  assign in_ready  = s1_adv;
  assign handshake = s2_valid_reg && out_ready;

`ifdef ENC_RANGE_CHECK_EN
  imm_range_check u_range_check (
    .cls    (in_class),
    .funct3 (in_funct3),
    .imm    (in_imm),
    .err    (range_err)
  );
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_class_reg  <= in_class;
        s1_funct3_reg <= in_funct3;
        s1_alt_reg    <= in_alt;
        s1_rd_reg     <= in_rd;
        s1_rs1_reg    <= in_rs1;
        s1_rs2_reg    <= in_rs2;
        s1_imm_reg    <= in_imm;
        s1_err_reg    <= range_err || !is_known_class(in_class);
      end
    end
  end

  always_comb begin
    pack_word = NOP_INSTR;
    case (s1_class_reg)
      CLS_OP:
        pack_word = {(s1_alt_reg ? 7'h20 : 7'h00), s1_rs2_reg, s1_rs1_reg,
                     s1_funct3_reg, s1_rd_reg, OPC_OP};
      CLS_OP_IMM: begin
        if (is_shift(s1_funct3_reg))
          pack_word = {1'b0, s1_alt_reg, 5'b0, s1_imm_reg[4:0], s1_rs1_reg,
                       s1_funct3_reg, s1_rd_reg, OPC_OP_IMM};
        else
          pack_word = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg, s1_rd_reg, OPC_OP_IMM};
      end
      CLS_LOAD:
        pack_word = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg, s1_rd_reg, OPC_LOAD};
      CLS_JALR:
        pack_word = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg, s1_rd_reg, OPC_JALR};
      CLS_STORE:
        pack_word = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                     s1_imm_reg[4:0], OPC_STORE};
      CLS_BRANCH:
        pack_word = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                     s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11], OPC_BRANCH};
      CLS_JAL:
        pack_word = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                     s1_imm_reg[19:12], s1_rd_reg, OPC_JAL};
      CLS_LUI:   pack_word = {s1_imm_reg[31:12], s1_rd_reg, OPC_LUI};
      CLS_AUIPC: pack_word = {s1_imm_reg[31:12], s1_rd_reg, OPC_AUIPC};
      default:   pack_word = NOP_INSTR;
    endcase
  end

  // Output registers only load when a word moves in, so a stalled word stays stable
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg  <= 1'b0;
      out_instr_reg <= '0;
      out_err_reg   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_instr_reg <= pack_word;
        out_err_reg   <= s1_err_reg;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_err   = out_err_reg;

  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_bus;

  assign cnt_inc[0] = handshake;
  assign cnt_inc[1] = handshake && out_err_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset)
          cnt_reg <= '0;
        else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
      assign cnt_bus[gi] = cnt_reg;
    end
  endgenerate

  assign enc_count = cnt_bus[0];
  assign err_count = cnt_bus[1];

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic against a field-level model.
module tb_instr_encoder;

  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam int C_OP = 0, C_OP_IMM = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_class = '0;
  logic [2:0]       in_funct3 = '0;
  logic             in_alt = 1'b0;
  logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count, err_count;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_alt    (in_alt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0, failed = 0, total = 0;
  int          enc_m = 0, err_m = 0;
  logic        acc_flag, obs_out_valid, obs_out_err, obs_in_ready;
  logic [31:0] obs_out_instr;
  logic [31:0] last_word;
  logic        last_err;
  int          cyc;
  logic        saw_block;
  int          enc_before;
  int          bnd[17] = '{2047, 2048, -2048, -2049, 4095, 4096, 4094, 8190, 8192,
                           -4096, -4098, 1048574, 1048576, -1048576, 31, 32, 32'h12345000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from the ISA field placement with plain shifts and masks
  function automatic logic [32:0] ref_encode(int cls, int f3, bit alt, int rd, int rs1, int rs2,
                                             bit [31:0] imm);
    bit [31:0] w;
    bit        e;
    longint    s;
    bit        shift;
    s = longint'($signed(imm));
    w = 32'h13;
    e = 1'b0;
    shift = (cls == C_OP_IMM) && (f3 == 1 || f3 == 5);
    case (cls)
      C_OP: w = 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (alt ? 32'h4000_0000 : 0);
      C_OP_IMM: begin
        if (shift) w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (alt ? 32'h4000_0000 : 0);
        else       w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      end
      C_LOAD:  w = 32'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      C_JALR:  w = 32'h67 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      C_STORE: w = 32'h23 | ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 127) << 25);
      C_BRANCH: w = 32'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12) | (rs1 << 15)
                    | (rs2 << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      C_JAL: w = 32'h6F | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                 | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
      C_LUI:   w = 32'h37 | (rd << 7) | (imm & 32'hFFFF_F000);
      C_AUIPC: w = 32'h17 | (rd << 7) | (imm & 32'hFFFF_F000);
      default: begin w = 32'h13; e = 1'b1; end
    endcase
    if (RANGE_ON) begin
      case (cls)
        C_OP_IMM: begin
          if (shift)        e = imm > 31;
          else if (f3 == 3) e = imm > 4095;
          else              e = (s < -2048) || (s > 2047);
        end
        C_LOAD: begin
          if (f3 == 4 || f3 == 5) e = imm > 4095;
          else                    e = (s < -2048) || (s > 2047);
        end
        C_JALR, C_STORE: e = (s < -2048) || (s > 2047);
        C_BRANCH: begin
          if (f3 == 6 || f3 == 7) e = (imm > 8190) || imm[0];
          else                    e = (s < -4096) || (s > 4094) || imm[0];
        end
        C_JAL: e = (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2) || imm[0];
        C_LUI, C_AUIPC: e = (imm & 32'hFFF) != 0;
        default: ;
      endcase
    end
    return {e, w};
  endfunction

  // One clock: observe and score at the falling edge, then step past the rising edge
  task automatic cycle();
    logic [32:0] r;
    @(negedge clk);
    obs_out_valid = out_valid;
    obs_out_instr = out_instr;
    obs_out_err   = out_err;
    obs_in_ready  = in_ready;
    acc_flag      = 1'b0;
    if (reset) begin
      sb.delete();
      enc_m = 0;
      err_m = 0;
    end else begin
      check("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < 2) || out_ready});
      if (sb.size() == 0) check("no_word_expected", {31'b0, out_valid}, 32'd0);
      if (out_valid && sb.size() > 0) begin
        check("out_instr", out_instr, sb[0].w);
        check("out_err", {31'b0, out_err}, {31'b0, sb[0].e});
        if (out_ready) begin
          last_word = out_instr;
          last_err  = out_err;
          if (enc_m < CMAX) enc_m++;
          if (sb[0].e && err_m < CMAX) err_m++;
          $display("word %08h err %0d enc_count_model %0d", out_instr, out_err, enc_m);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        acc_flag = 1'b1;
        r = ref_encode(int'(in_class), int'(in_funct3), in_alt, int'(in_rd), int'(in_rs1),
                       int'(in_rs2), in_imm);
        sb.push_back('{w: r[31:0], e: r[32]});
      end
    end
    @(posedge clk);
    #1;
    check("enc_count", 32'(enc_count), 32'(enc_m));
    check("err_count", 32'(err_count), 32'(err_m));
  endtask

  task automatic set_in(int cls, int f3, bit alt, int rd, int rs1, int rs2, bit [31:0] imm);
    in_class  = 4'(cls);
    in_funct3 = 3'(f3);
    in_alt    = alt;
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  task automatic set_random();
    int pick;
    pick = $urandom_range(0, 9);
    in_class  = (pick == 9) ? 4'hF : 4'(pick);
    in_funct3 = 3'($urandom_range(0, 7));
    in_alt    = 1'($urandom_range(0, 1));
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       in_imm = 32'($urandom_range(0, 40));
      1:       in_imm = -32'($urandom_range(0, 40));
      2:       in_imm = 32'(bnd[$urandom_range(0, 16)]);
      default: in_imm = $urandom;
    endcase
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (acc_flag) break;
    end
    check("accept", {31'b0, acc_flag}, 32'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) cycle();
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic send_one(int cls, int f3, bit alt, int rd, int rs1, int rs2, bit [31:0] imm);
    set_in(cls, f3, alt, rd, rs1, rs2, imm);
    wait_accept();
    drain();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);

    // ADDI x1,x0,5 and its latency
    set_in(C_OP_IMM, 0, 0, 1, 0, 0, 32'd5);
    wait_accept();
    in_valid = 1'b0;
    cycle();
    check("lat_n1_valid", {31'b0, obs_out_valid}, 32'd0);
    cycle();
    check("lat_n2_valid", {31'b0, obs_out_valid}, 32'd1);
    check("addi_word", obs_out_instr, 32'h0050_0093);
    check("addi_err", {31'b0, obs_out_err}, 32'd0);
    drain();

    // Directed golden words
    send_one(C_OP, 0, 1, 3, 1, 2, 32'd0);
    check("sub_word", last_word, 32'h4020_81B3);
    send_one(C_BRANCH, 0, 0, 0, 1, 2, 32'd8);
    check("beq_word", last_word, 32'h0020_8463);
    send_one(C_JAL, 0, 0, 1, 0, 0, 32'd2048);
    check("jal_word", last_word, 32'h0010_00EF);
    send_one(C_LUI, 0, 0, 5, 0, 0, 32'h1234_5000);
    check("lui_word", last_word, 32'h1234_52B7);

    // Error boundaries
    send_one(C_OP_IMM, 0, 0, 1, 0, 0, 32'd2048);
    check("addi2048_err", {31'b0, last_err}, {31'b0, RANGE_ON});
    send_one(C_BRANCH, 0, 0, 0, 1, 2, 32'd3);
    check("beq_odd_err", {31'b0, last_err}, {31'b0, RANGE_ON});
    send_one(15, 0, 0, 7, 7, 7, 32'hFFFF_FFFF);
    check("unknown_word", last_word, 32'h0000_0013);
    check("unknown_err", {31'b0, last_err}, 32'd1);

    // Eight back-to-back words with a 3-cycle downstream stall
    enc_before = enc_m;
    saw_block  = 1'b0;
    cyc        = 0;
    for (int i = 0; i < 8; i++) begin
      set_random();
      for (int k = 0; k < 50; k++) begin
        out_ready = !(cyc >= 3 && cyc < 6);
        cyc++;
        cycle();
        if (!obs_in_ready) saw_block = 1'b1;
        if (acc_flag) break;
      end
    end
    drain();
    check("stream_count", 32'(enc_count), 32'(enc_before + 8));
    check("in_ready_dropped", {31'b0, saw_block}, 32'd1);

    // Reset with two words in flight
    out_ready = 1'b0;
    set_random();
    wait_accept();
    set_random();
    wait_accept();
    in_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst2_enc_count", 32'(enc_count), 32'd0);
    out_ready = 1'b1;
    send_one(C_STORE, 2, 0, 0, 3, 4, 32'hFFFF_FFFC);
    check("post_rst_count", 32'(enc_count), 32'd1);

    // Randomized traffic with random backpressure and bubbles
    for (int i = 0; i < 30; i++) begin
      set_random();
      for (int k = 0; k < 50; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
        if (acc_flag) break;
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        cycle();
      end
    end
    drain();

    // Counter saturation
    out_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      set_random();
      wait_accept();
    end
    drain();
    check("enc_saturated", 32'(enc_count), 32'(CMAX));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
